// File: rtl/write_pointer_ctrl_pkg.sv
// Shared FIFO definitions for the write-side controller: geometry and FSM state encodings.
package write_pointer_ctrl_pkg;
  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wr_state_e;
endpackage

// File: rtl/write_pointer_ctrl_fifo_occupancy.sv
// Occupancy counter with full/empty decode; almost_full is live only when ALMOST_FULL_EN is defined.
module write_pointer_ctrl_fifo_occupancy #(
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic          clk,
  input  logic          rst_edge,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [ADDR_W:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  logic [ADDR_W:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_edge) begin
    if (!rst_edge) count_q <= '0;
    else           count_q <= count_d;
  end

  // A simultaneous read and write leaves the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en)                         count_d = count_q + ONE;
    else if (rd_en && !wr_en && count_q != '0)   count_d = count_q - ONE;
  end

  assign count = count_q;
  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);

`ifdef ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AF_THR = (ADDR_W+1)'(AF_LEVEL);
  assign almost_full = (count_q >= AF_THR);
`else
  logic [31:0] unused_af_level;
  assign unused_af_level = 32'(AF_LEVEL);
  assign almost_full     = 1'b0;
`endif
endmodule

// File: rtl/write_pointer_ctrl.sv
// Write-side FIFO controller: single/burst write FSM, write pointer and sticky overflow.
// Optional almost-full output enabled by defining ALMOST_FULL_EN.
module write_pointer_ctrl
  import write_pointer_ctrl_pkg::*;
#(
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = FIFO_DEPTH - 4
) (
  input  logic              clk,
  input  logic              rst_edge,
  input  logic              pisi,
  input  logic              pisiVise,
  input  logic [ADDR_W-1:0] duzina,
  input  logic              fifo_rd,
  input  logic              clr_ovf,
  output logic [ADDR_W-1:0] wptr,
  output logic              fifo_we,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              wr_busy,
  output logic              overflow,
  output logic              almost_full
);
  localparam logic [ADDR_W-1:0] REM_ONE = ADDR_W'(1);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              ovf_q, ovf_d;
  logic              req, start;

  always_ff @(posedge clk or negedge rst_edge) begin
    if (!rst_edge) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_BURST;
      ST_BURST: if (fifo_we && rem_q == REM_ONE) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The write strobe is held off during reset so the memory never sees a stray write.
  always_comb begin
    start   = (state_q == ST_IDLE) && pisiVise && (duzina != '0);
    req     = (state_q == ST_BURST) || ((state_q == ST_IDLE) && pisi && !pisiVise);
    fifo_we = req && !fifo_full && rst_edge;
    wr_busy = (state_q == ST_BURST) || start;
  end

  always_ff @(posedge clk or negedge rst_edge) begin
    if (!rst_edge) begin
      wptr_q <= '0;
      rem_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rem_q  <= rem_d;
      ovf_q  <= ovf_d;
    end
  end

  // A burst stalls with remaining held while full; a refused request beats clr_ovf.
  always_comb begin
    wptr_d = wptr_q + ADDR_W'(fifo_we);
    rem_d  = rem_q;
    if (start)                                 rem_d = duzina;
    else if (state_q == ST_BURST && fifo_we)   rem_d = rem_q - REM_ONE;
    ovf_d  = (req && fifo_full) || (ovf_q && !clr_ovf);
  end

  assign wptr     = wptr_q;
  assign overflow = ovf_q;

  write_pointer_ctrl_fifo_occupancy #(
    .ADDR_W   (ADDR_W),
    .AF_LEVEL (AF_LEVEL)
  ) u_occ (
    .clk         (clk),
    .rst_edge    (rst_edge),
    .wr_en       (fifo_we),
    .rd_en       (fifo_rd),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (almost_full)
  );
endmodule

// File: tb/tb_write_pointer_ctrl.sv
// Directed bench for write_pointer_ctrl: a vector table plus hand-written multi-cycle sequences.
module tb_write_pointer_ctrl;
  logic       clk = 1'b0;
  logic       rst_edge;
  logic       pisi, pisiVise, fifo_rd, clr_ovf;
  logic [3:0] duzina;
  logic [3:0] wptr;
  logic       fifo_we, fifo_full, fifo_empty, wr_busy, overflow, almost_full;
  logic [4:0] fifo_count;

  always #5 clk = ~clk;

  write_pointer_ctrl dut (
    .clk         (clk),
    .rst_edge    (rst_edge),
    .pisi        (pisi),
    .pisiVise    (pisiVise),
    .duzina      (duzina),
    .fifo_rd     (fifo_rd),
    .clr_ovf     (clr_ovf),
    .wptr        (wptr),
    .fifo_we     (fifo_we),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_count  (fifo_count),
    .wr_busy     (wr_busy),
    .overflow    (overflow),
    .almost_full (almost_full)
  );

  typedef struct {
    bit         pisi, pv;
    logic [3:0] dz;
    bit         rd, clr;
    bit         we;
    int         wp, cnt;
    bit         busy, ovf;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[16];

  function automatic vec_t mk(bit p, bit pv, int dz, bit rd, bit clr,
                              bit we, int wp, int cnt, bit busy, bit ovf);
    vec_t m;
    m.pisi = p;  m.pv = pv; m.dz = dz[3:0]; m.rd = rd; m.clr = clr;
    m.we = we;   m.wp = wp; m.cnt = cnt;    m.busy = busy; m.ovf = ovf;
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_state(string tag, bit we, int wp, int cnt, bit busy, bit ovf);
    bit af;
`ifdef ALMOST_FULL_EN
    af = (cnt >= 12);
`else
    af = 1'b0;
`endif
    chk({tag, " we"},    32'(fifo_we),    32'(we));
    chk({tag, " wptr"},  32'(wptr),       32'(wp));
    chk({tag, " count"}, 32'(fifo_count), 32'(cnt));
    chk({tag, " full"},  32'(fifo_full),  32'(cnt == 16));
    chk({tag, " empty"}, 32'(fifo_empty), 32'(cnt == 0));
    chk({tag, " busy"},  32'(wr_busy),    32'(busy));
    chk({tag, " ovf"},   32'(overflow),   32'(ovf));
    chk({tag, " af"},    32'(almost_full), 32'(af));
  endtask

  // Called at a negedge: drive, check just after, advance to the next negedge.
  task automatic cyc(input vec_t v, input string tag);
    pisi = v.pisi; pisiVise = v.pv; duzina = v.dz; fifo_rd = v.rd; clr_ovf = v.clr;
    #1;
    check_state(tag, v.we, v.wp, v.cnt, v.busy, v.ovf);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_edge = 1'b0;
    pisi = 0; pisiVise = 0; duzina = 0; fifo_rd = 0; clr_ovf = 0;
    @(negedge clk);
    @(negedge clk);
    rst_edge = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 7; i++) tbl[i] = mk(1,0,0,0,0, 1,i,i,0,0);
    tbl[7]  = mk(1,0,0,1,0, 1,7,7,0,0);
    tbl[8]  = mk(0,0,0,0,0, 0,8,7,0,0);
    tbl[9]  = mk(1,1,0,0,0, 0,8,7,0,0);
    tbl[10] = mk(1,1,2,0,0, 0,8,7,1,0);
    tbl[11] = mk(1,0,0,0,0, 1,8,7,1,0);
    tbl[12] = mk(0,0,0,0,0, 1,9,8,1,0);
    tbl[13] = mk(0,0,0,0,0, 0,10,9,0,0);
    tbl[14] = mk(0,0,0,1,0, 0,10,9,0,0);
    tbl[15] = mk(0,0,0,0,0, 0,10,8,0,0);

    // Reset held with pisi asserted, then release straight into writes
    rst_edge = 1'b0;
    pisi = 1; pisiVise = 0; duzina = 0; fifo_rd = 0; clr_ovf = 0;
    @(negedge clk);
    #1;
    check_state("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_edge = 1'b1;
    for (int i = 0; i < 16; i++) cyc(tbl[i], $sformatf("tbl[%0d]", i));

    // Fill to full, refused write, overflow set/clear priority, read+pisi while full
    do_reset();
    for (int i = 0; i < 16; i++) cyc(mk(1,0,0,0,0, 1,i,i,0,0), "fill16");
    cyc(mk(1,0,0,0,0, 0,0,16,0,0), "17th");
    cyc(mk(1,0,0,0,1, 0,0,16,0,1), "setwins");
    cyc(mk(0,0,0,0,1, 0,0,16,0,1), "clr");
    cyc(mk(1,0,0,1,0, 0,0,16,0,0), "rdpisi_full");
    cyc(mk(0,0,0,0,0, 0,0,15,0,1), "after_rdpisi");

    // Five-word burst from empty
    do_reset();
    cyc(mk(0,1,5,0,0, 0,0,0,1,0), "b5 start");
    for (int i = 0; i < 5; i++) cyc(mk(0,0,0,0,0, 1,i,i,1,0), "b5 word");
    cyc(mk(0,0,0,0,0, 0,5,5,0,0), "b5 done");

    // Burst of 4 at count 14: stall while full, drained by two reads
    do_reset();
    for (int i = 0; i < 14; i++) cyc(mk(1,0,0,0,0, 1,i,i,0,0), "fill14");
    cyc(mk(0,1,4,0,0, 0,14,14,1,0), "b4 start");
    cyc(mk(0,0,0,0,0, 1,14,14,1,0), "b4 w1");
    cyc(mk(0,0,0,0,0, 1,15,15,1,0), "b4 w2");
    cyc(mk(0,0,0,0,0, 0,0,16,1,0), "b4 stall1");
    cyc(mk(0,0,0,0,0, 0,0,16,1,1), "b4 stall2");
    cyc(mk(0,0,0,1,0, 0,0,16,1,1), "b4 rd1");
    cyc(mk(0,0,0,1,0, 1,0,15,1,1), "b4 rd2");
    cyc(mk(0,0,0,0,0, 1,1,15,1,1), "b4 w4");
    cyc(mk(0,0,0,0,0, 0,2,16,0,1), "b4 done");

    // Asynchronous reset mid-burst with three words remaining
    do_reset();
    cyc(mk(0,1,5,0,0, 0,0,0,1,0), "mid start");
    cyc(mk(0,0,0,0,0, 1,0,0,1,0), "mid w1");
    cyc(mk(0,0,0,0,0, 1,1,1,1,0), "mid w2");
    #3 rst_edge = 1'b0;
    #1;
    check_state("mid reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_edge = 1'b1;
    cyc(mk(0,0,0,0,0, 0,0,0,0,0), "mid after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
